// File: rtl/adc_spi_reader_if.sv
// SPI pin bundle between the MCP3202 reader (master) and the ADC (slave).
interface adc_spi_reader_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs_n, output mosi, input miso);
  modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/adc_spi_reader.sv
// SPI master that reads 12-bit samples from an MCP3202 ADC, channel 0 for
// player 1 and (in two-player mode) alternating channel 1 for player 2.
module adc_spi_reader #(
  parameter int CLK_DIV = 30,
  parameter int CS_IDLE = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               two_player,
  adc_spi_reader_if.master   spi,
  output logic [11:0]        p1data,
  output logic [11:0]        p2data,
  output logic               p1_valid,
  output logic               p2_valid,
  output logic               busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  localparam int CNT_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(CS_IDLE - 1);
  localparam logic [5:0]    LAST_TICK = 6'd33;

  logic [2:0]    state_r;
  logic [CW-1:0] cnt_r;
  logic [5:0]    tick_r;
  logic          ch_r;
  logic          fch_r;
  logic [11:0]   sr_r;
  logic          cs_n_r;
  logic          sclk_r;
  logic          mosi_r;
  logic [11:0]   p1data_r;
  logic [11:0]   p2data_r;
  logic          p1_valid_r;
  logic          p2_valid_r;
  logic          busy_r;
  logic [4:0]    bit_idx_s;

  // Each SCLK period spans two ticks, so tick_r/2 is the zero-based bit slot.
  assign bit_idx_s = tick_r[5:1];

  assign spi.sclk = sclk_r;
  assign spi.cs_n = cs_n_r;
  assign spi.mosi = mosi_r;
  assign p1data   = p1data_r;
  assign p2data   = p2data_r;
  assign p1_valid = p1_valid_r;
  assign p2_valid = p2_valid_r;
  assign busy     = busy_r;

  // Frame sequencer: state, timing counters, SPI pins and sample registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      tick_r     <= 6'd0;
      ch_r       <= 1'b0;
      fch_r      <= 1'b0;
      sr_r       <= 12'd0;
      cs_n_r     <= 1'b1;
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
      p1data_r   <= 12'd0;
      p2data_r   <= 12'd0;
      p1_valid_r <= 1'b0;
      p2_valid_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      p1_valid_r <= 1'b0;
      p2_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (enable) begin
            state_r <= SETUP;
            fch_r   <= ch_r;
            cnt_r   <= '0;
            cs_n_r  <= 1'b0;
            mosi_r  <= 1'b1;
            busy_r  <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_r == DIV_LAST) begin
            state_r <= SHIFT;
            cnt_r   <= '0;
            tick_r  <= 6'd0;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt_r == DIV_LAST) begin
            cnt_r  <= '0;
            tick_r <= tick_r + 6'd1;
            sclk_r <= ~sclk_r;
            if (tick_r == LAST_TICK) begin
              state_r <= DONE;
              sclk_r  <= 1'b0;
              cs_n_r  <= 1'b1;
              mosi_r  <= 1'b0;
              if (fch_r) begin
                p2data_r   <= sr_r;
                p2_valid_r <= 1'b1;
              end else begin
                p1data_r   <= sr_r;
                p1_valid_r <= 1'b1;
              end
            end else if (!sclk_r) begin
              // Rising edge: slots 0..4 carry command and null bits.
              if (bit_idx_s >= 5'd5 && bit_idx_s <= 5'd16) begin
                sr_r <= {sr_r[10:0], spi.miso};
              end
            end else begin
              case (bit_idx_s)
                5'd0:    mosi_r <= 1'b1;
                5'd1:    mosi_r <= fch_r;
                5'd2:    mosi_r <= 1'b1;
                default: mosi_r <= 1'b0;
              endcase
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        DONE: begin
          ch_r    <= two_player ? ~ch_r : 1'b0;
          state_r <= GAP;
          cnt_r   <= '0;
        end
        GAP: begin
          if (cnt_r == GAP_LAST) begin
            cnt_r <= '0;
            if (enable) begin
              state_r <= SETUP;
              fch_r   <= ch_r;
              cs_n_r  <= 1'b0;
              mosi_r  <= 1'b1;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          cs_n_r  <= 1'b1;
          sclk_r  <= 1'b0;
          mosi_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: behavioural MCP3202 on the SPI pins plus a
// frame-level reference model of channel order, data, command and timing.
module tb_adc_spi_reader;
  localparam int CLK_DIV = 2;
  localparam int CS_IDLE = 3;
  localparam int PERIOD  = CLK_DIV + 34 * CLK_DIV + 1 + CS_IDLE;

  logic clk = 1'b0;
  logic reset, enable, two_player;
  logic [11:0] p1data, p2data;
  logic p1_valid, p2_valid, busy;
  logic miso_drv = 1'b0;

  adc_spi_reader_if spi();
  assign spi.miso = miso_drv;

  adc_spi_reader #(.CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE)) dut (
    .clk(clk), .reset(reset), .enable(enable), .two_player(two_player),
    .spi(spi), .p1data(p1data), .p2data(p2data),
    .p1_valid(p1_valid), .p2_valid(p2_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural MCP3202 ----------------
  logic [11:0] adc_val [2];
  logic        in_frame = 1'b0, prev_sclk = 1'b0;
  int          rise_n = 0, fall_n = 0, rise_total = 0;
  logic [3:0]  cmd = 4'd0, frame_cmd = 4'd0;
  logic [11:0] word = 12'd0;

  always @(spi.sclk or spi.cs_n) begin
    if (spi.cs_n) begin
      in_frame = 1'b0;
      miso_drv = 1'b0;
    end else begin
      if (!in_frame) begin
        in_frame = 1'b1; rise_n = 0; fall_n = 0; cmd = 4'd0; prev_sclk = spi.sclk;
      end
      if (spi.sclk && !prev_sclk) begin
        rise_n++; rise_total++;
        if (rise_n <= 4) cmd = {cmd[2:0], spi.mosi};
        if (rise_n == 4) begin frame_cmd = cmd; word = adc_val[cmd[1]]; end
      end else if (!spi.sclk && prev_sclk) begin
        fall_n++;
        if (fall_n >= 5 && fall_n <= 16) miso_drv = word[16 - fall_n];
        else miso_drv = 1'b0;
      end
    end
    prev_sclk = spi.sclk;
  end

  // ---------------- frame-level reference model ----------------
  int   pulse_tot = 0, p1_cnt = 0, p2_cnt = 0, prev_cyc = 0, hi_run = 0;
  logic exp_ch = 1'b0, have_prev = 1'b0;
  logic [11:0] m_p1 = 12'd0, m_p2 = 12'd0;

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (p1_valid || p2_valid) begin
        check("valid_channel", {30'd0, p1_valid, p2_valid}, exp_ch ? 32'd1 : 32'd2);
        check("command_word", {28'd0, frame_cmd}, {28'd0, 1'b1, 1'b1, exp_ch, 1'b1});
        if (exp_ch) m_p2 = adc_val[1]; else m_p1 = adc_val[0];
        check("p1data", {20'd0, p1data}, {20'd0, m_p1});
        check("p2data", {20'd0, p2data}, {20'd0, m_p2});
        if (have_prev) check("frame_period", cyc_n - prev_cyc, PERIOD);
        prev_cyc = cyc_n; have_prev = 1'b1;
        pulse_tot++;
        if (exp_ch) p2_cnt++; else p1_cnt++;
        exp_ch = two_player ? ~exp_ch : 1'b0;
      end
      if (spi.cs_n) hi_run++;
      else begin
        if (have_prev && hi_run != 0) check("cs_high_gap", hi_run, CS_IDLE + 1);
        hi_run = 0;
      end
      if (reset) begin
        exp_ch = 1'b0; m_p1 = 12'd0; m_p2 = 12'd0; have_prev = 1'b0; hi_run = 0;
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(); cyc(); reset = 1'b0;
  endtask

  task automatic wait_pulses(input int target);
    int k = 0;
    while (pulse_tot < target && k < PERIOD * 6) begin cyc(); k++; end
    check("pulse_wait", pulse_tot, target);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < PERIOD * 3) begin cyc(); k++; end
    check("idle_wait", {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic tp; logic [11:0] v0, v1; int n;
    logic [11:0] e1, e2; int c1, c2;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int b1, b2, k, r0, lows, n, a1, a2;
    logic [11:0] v0, v1;
    vecs[0] = '{1'b0, 12'hA5C, 12'h777, 1, 12'hA5C, 12'h000, 1, 0};
    vecs[1] = '{1'b0, 12'hFFF, 12'h123, 2, 12'hFFF, 12'h000, 2, 0};
    vecs[2] = '{1'b1, 12'h000, 12'hFFF, 3, 12'h000, 12'hFFF, 2, 1};
    vecs[3] = '{1'b1, 12'h800, 12'h001, 4, 12'h800, 12'h001, 2, 2};
    vecs[4] = '{1'b1, 12'h5A5, 12'hA5A, 2, 12'h5A5, 12'hA5A, 1, 1};

    reset = 1'b1; enable = 1'b0; two_player = 1'b0;
    adc_val[0] = 12'h000; adc_val[1] = 12'h000;
    fork monitor(); join_none
    repeat (3) cyc();
    check("rst_cs_n", {31'd0, spi.cs_n}, 32'd1);
    check("rst_sclk", {31'd0, spi.sclk}, 32'd0);
    check("rst_mosi", {31'd0, spi.mosi}, 32'd0);
    check("rst_p1data", {20'd0, p1data}, 32'd0);
    check("rst_p2data", {20'd0, p2data}, 32'd0);
    check("rst_valids", {30'd0, p1_valid, p2_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    // Table-driven runs: n frames with enable held, then stop.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      two_player = vecs[i].tp; adc_val[0] = vecs[i].v0; adc_val[1] = vecs[i].v1;
      b1 = p1_cnt; b2 = p2_cnt;
      enable = 1'b1;
      wait_pulses(pulse_tot + vecs[i].n);
      enable = 1'b0;
      wait_idle();
      check("vec_p1data", {20'd0, p1data}, {20'd0, vecs[i].e1});
      check("vec_p2data", {20'd0, p2data}, {20'd0, vecs[i].e2});
      check("vec_p1_count", p1_cnt - b1, vecs[i].c1);
      check("vec_p2_count", p2_cnt - b2, vecs[i].c2);
    end

    // enable dropped during SHIFT: frame completes, then stop after GAP.
    do_reset();
    two_player = 1'b0; adc_val[0] = 12'h123; b1 = p1_cnt;
    enable = 1'b1; r0 = rise_total; k = 0;
    while (rise_total < r0 + 3 && k < 200) begin cyc(); k++; end
    check("reached_shift", rise_total - r0, 3);
    enable = 1'b0;
    wait_pulses(pulse_tot + 1);
    k = 0;
    while (busy && k < 50) begin cyc(); k++; end
    check("busy_fall_delay", k, CS_IDLE);
    check("drop_p1data", {20'd0, p1data}, 32'h123);
    check("drop_p1_count", p1_cnt - b1, 1);
    r0 = rise_total; lows = 0;
    repeat (40) begin cyc(); if (!spi.cs_n || spi.sclk) lows++; end
    check("drop_quiet_pins", lows, 0);
    check("drop_no_sclk", rise_total - r0, 0);

    // Reset at rise 10 of a ch1 frame; fresh frame must be ch0.
    do_reset();
    two_player = 1'b1; adc_val[0] = 12'h3C3; adc_val[1] = 12'h456;
    enable = 1'b1;
    wait_pulses(pulse_tot + 1);
    k = 0;
    while (!(in_frame && rise_n == 10) && k < 300) begin cyc(); k++; end
    check("reached_rise10", rise_n, 10);
    reset = 1'b1; cyc();
    check("midrst_cs_n", {31'd0, spi.cs_n}, 32'd1);
    check("midrst_sclk", {31'd0, spi.sclk}, 32'd0);
    check("midrst_p1data", {20'd0, p1data}, 32'd0);
    check("midrst_p2data", {20'd0, p2data}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0; b2 = p2_cnt;
    wait_pulses(pulse_tot + 1);
    check("midrst_fresh_ch0", p2_cnt - b2, 0);
    enable = 1'b0;
    wait_idle();

    // two_player 1->0 during a ch1 frame: that frame still updates p2data.
    do_reset();
    two_player = 1'b1; adc_val[0] = 12'h0AA; adc_val[1] = 12'h955;
    b1 = p1_cnt; b2 = p2_cnt; enable = 1'b1;
    wait_pulses(pulse_tot + 1);
    k = 0;
    while (spi.cs_n && k < 50) begin cyc(); k++; end
    repeat (10) cyc();
    two_player = 1'b0;
    wait_pulses(pulse_tot + 4);
    enable = 1'b0;
    wait_idle();
    check("tpdrop_p1_count", p1_cnt - b1, 4);
    check("tpdrop_p2_count", p2_cnt - b2, 1);
    check("tpdrop_p2data", {20'd0, p2data}, 32'h955);

    // Randomized runs with random data and two_player flips.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      v0 = 12'($urandom_range(4095, 0)); v1 = 12'($urandom_range(4095, 0));
      adc_val[0] = v0; adc_val[1] = v1;
      two_player = 1'($urandom_range(1, 0));
      n = $urandom_range(4, 1);
      b1 = p1_cnt; b2 = p2_cnt; r0 = pulse_tot + n; k = 0;
      enable = 1'b1;
      while (pulse_tot < r0 && k < PERIOD * 6) begin
        cyc(); k++;
        if ($urandom_range(39, 0) == 0) two_player = ~two_player;
      end
      check("rand_pulse_wait", pulse_tot, r0);
      enable = 1'b0;
      wait_idle();
      a1 = p1_cnt - b1; a2 = p2_cnt - b2;
      check("rand_p1data", {20'd0, p1data}, (a1 > 0) ? {20'd0, v0} : 32'd0);
      check("rand_p2data", {20'd0, p2data}, (a2 > 0) ? {20'd0, v1} : 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/adc_spi_reader.md
Name: adc_spi_reader

Overview:
- SPI master that reads player input voltages from an external MCP3202 dual-channel 12-bit ADC.
- Produces the 12-bit p1data/p2data samples consumed by the game/quantizer logic.
- Channel 0 is player 1 and channel 1 is player 2.
- In single-player mode only channel 0 is converted. In two-player mode conversions alternate ch0, ch1, ch0, …

Parameters:
- CLK_DIV, 30: clk cycles per SCLK half-period (SCLK = f_clk / (2*CLK_DIV)); must be ≥1.
- CS_IDLE, 30: clk cycles cs_n is held high between frames; must be ≥1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = run conversions continuously; 0 = stop after the current frame
- two_player  in  1  1 = alternate ch0/ch1; 0 = ch0 only
- miso  in  1  ADC DOUT
- sclk  out  1  SPI clock; idles low
- cs_n  out  1  ADC chip select, active low
- mosi  out  1  ADC DIN
- p1data  out  12  last completed ch0 sample
- p2data  out  12  last completed ch1 sample
- p1_valid  out  1  one-cycle pulse when p1data updates
- p2_valid  out  1  one-cycle pulse when p2data updates
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset applies on a clk edge with reset=1 and overrides everything, including mid-frame. All outputs then read:
  - cs_n=1, sclk=0, mosi=0
  - p1data=0, p2data=0
  - p1_valid=0, p2_valid=0, busy=0
  - Internal state: state=IDLE, channel register ch=0, all counters 0.
- States: IDLE, SETUP, SHIFT, DONE, GAP.
- IDLE:
  - cs_n=1, sclk=0.
  - If enable=1, go to SETUP next cycle and latch the frame channel from ch.
- SETUP:
  - Lasts CLK_DIV cycles; cs_n=0, sclk=0.
  - mosi=1 (start bit).
- SHIFT:
  - A divider counts 0..CLK_DIV-1; the terminal count ("tick") toggles sclk.
  - 34 ticks give 17 full SCLK periods.
  - On each rising toggle k (k=1..17):
    - k=1..4: no sample; the ADC latches command bits.
    - k=5: null bit, ignored.
    - k=6..17: shift miso into a 12-bit shift register, MSB first (B11 at k=6, B0 at k=17).
  - On falling toggle k (k=1..16), mosi is updated:
    - after fall 1: SGL=1
    - after fall 2: ODD = frame channel
    - after fall 3: MSBF=1
    - after fall 4 onward: 0
  - Command word on DIN is therefore 1,1,ch,1.
  - The 34th tick drives sclk low and moves to DONE.
- DONE (1 cycle):
  - cs_n=1; the shift register is copied to p1data (ch=0) or p2data (ch=1).
  - The matching valid pulses for exactly this cycle.
  - ch update: if two_player=1, ch toggles; otherwise ch=0.
  - Go to GAP.
- GAP:
  - Lasts CS_IDLE cycles with cs_n=1.
  - At the end: enable=1 goes to SETUP; enable=0 goes to IDLE.
- Frame period between consecutive valid pulses with enable held = CLK_DIV + 34*CLK_DIV + 1 + CS_IDLE cycles.
- enable deasserted mid-frame:
  - The frame completes normally, including its data update and valid pulse.
  - The block then returns to IDLE after GAP. enable is not sampled before the end of GAP.
- two_player changes mid-frame: no effect on the current frame; it only affects the ch update in DONE.
- Data registers hold their value until their own channel completes; an unsampled channel keeps its old value indefinitely.
- p1_valid and p2_valid are never high in the same cycle.
- miso is used directly. The ADC is synchronous to the sclk this block generates, so no synchronizer is needed.

Test Plan (CLK_DIV=2, CS_IDLE=3, behavioural MCP3202 model on the SPI pins):
- Reset, enable=1, two_player=0, model ch0=0xA5C:
  - mosi sampled on sclk rises 1..4 = 1,1,0,1.
  - p1data=0xA5C with a single p1_valid pulse.
  - p2data stays 0.
- Frame timing: enable held → consecutive p1_valid pulses exactly 74 cycles apart; cs_n high for 4 cycles (DONE + GAP) between frames.
- two_player=1, ch0=0x000, ch1=0xFFF:
  - Valid pulses alternate p1,p2,p1.
  - p1data=0x000, p2data=0xFFF.
  - ODD bit on rise 3 alternates 0,1,0.
- enable dropped during SHIFT of a ch0 frame, model 0x123:
  - Frame completes, p1data=0x123, p1_valid pulses once.
  - cs_n stays 1, busy falls after GAP, no further sclk edges.
- reset asserted at rise 10 of SHIFT:
  - Next cycle cs_n=1, sclk=0, p1data=p2data=0, busy=0.
  - With enable=1 and reset released, a fresh frame starts with the ch0 command.
- two_player toggled 1→0 during a ch1 frame: that frame updates p2data; all subsequent frames are ch0 only.
